flag_unit: RTL

FLAG_UNIT -- requirements
Module: flag_unit

---
 rtl/flag_unit.sv | 137 +++++++++++++
 1 files changed

// File: rtl/flag_unit.sv
// flag_unit: NZCV flag register, B.cond evaluation and taken-branch counter.
// Ports:
//   clk, reset_n (async, active low)
//   ex_*  : EX-stage valid, flag-setting strobe and ALU N/Z/V/C results
//   flush : squashes the EX and ID instructions this cycle
//   id_*  : ID-stage valid, B.cond strobe and 4-bit condition code
//   flags : committed {N,Z,C,V}
//   stall : hold IF/ID this cycle
//   br_valid / br_taken : registered branch decision (one cycle after request)
//   taken_count : wrapping count of taken B.cond
// Build option: define FLAG_FWD_EN to forward EX flags into the branch
// decision (no stall); otherwise a flag hazard stalls ID for one cycle.
module flag_unit (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ex_valid,
    input  logic        ex_set_flags,
    input  logic        ex_negative,
    input  logic        ex_zero,
    input  logic        ex_overflow,
    input  logic        ex_carry_out,
    input  logic        flush,
    input  logic        id_valid,
    input  logic        id_bcond,
    input  logic [3:0]  id_cond,
    output logic [3:0]  flags,
    output logic        stall,
    output logic        br_valid,
    output logic        br_taken,
    output logic [31:0] taken_count
);

    typedef enum logic {
        RUN  = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;

    logic       ex_wr;
    logic       req_terms;
    logic       br_req;
    logic       cond_true;
    logic [3:0] eff;

    assign ex_wr     = ex_valid & ex_set_flags & ~flush;
    assign req_terms = id_valid & id_bcond & ~flush;
    assign br_req    = req_terms & ~stall;

`ifdef FLAG_FWD_EN
    // EX result bypasses the flag register for a same-cycle B.cond.
    assign eff = ex_wr ?
        {ex_negative, ex_zero, ex_carry_out, ex_overflow} : flags;

    always_comb begin
        stall     = 1'b0;
        state_nxt = RUN;
        case (state)
            RUN:     state_nxt = RUN;
            WAIT:    state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end
`else
    logic hazard;

    assign eff = flags;

    // Gated by reset_n so stall reads 0 while reset is held.
    assign hazard = req_terms & ex_valid & ex_set_flags & reset_n;

    // WAIT is the cycle after a hazard: the flags are committed, so the
    // held branch normally goes through; a fresh hazard stalls again.
    always_comb begin
        stall     = 1'b0;
        state_nxt = RUN;
        case (state)
            RUN: begin
                stall     = hazard;
                state_nxt = hazard ? WAIT : RUN;
            end
            WAIT: begin
                stall     = hazard;
                state_nxt = hazard ? WAIT : RUN;
            end
            default: begin
                stall     = 1'b0;
                state_nxt = RUN;
            end
        endcase
    end
`endif

    // Condition decode on {N,Z,C,V}; 1111 behaves as AL.
    always_comb begin
        logic n, z, c, v;
        {n, z, c, v} = eff;
        cond_true    = 1'b0;
        case (id_cond)
            4'b0000: cond_true = z;
            4'b0001: cond_true = ~z;
            4'b0010: cond_true = c;
            4'b0011: cond_true = ~c;
            4'b0100: cond_true = n;
            4'b0101: cond_true = ~n;
            4'b0110: cond_true = v;
            4'b0111: cond_true = ~v;
            4'b1000: cond_true = c & ~z;
            4'b1001: cond_true = ~(c & ~z);
            4'b1010: cond_true = (n == v);
            4'b1011: cond_true = (n != v);
            4'b1100: cond_true = ~z & (n == v);
            4'b1101: cond_true = ~(~z & (n == v));
            default: cond_true = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= RUN;
            flags       <= 4'b0000;
            br_valid    <= 1'b0;
            br_taken    <= 1'b0;
            taken_count <= 32'd0;
        end else begin
            state    <= state_nxt;
            br_valid <= br_req;
            br_taken <= br_req & cond_true;
            if (ex_wr)
                flags <= {ex_negative, ex_zero, ex_carry_out, ex_overflow};
            if (br_req & cond_true)
                taken_count <= taken_count + 32'd1;
        end
    end

endmodule
